// File: rtl/ace_read_arbiter.sv
// rtl/ace_read_arbiter.sv - round-robin ACE read arbiter with ID-prefix R routing
// Define ACE_RD_ARB_BARRIER_EN to hold barrier reads until their requester has drained.
module ace_read_arbiter #(
  parameter  int NoMst      = 2,
  parameter  int IdWidth    = 4,
  parameter  int ArPldWidth = 64,
  parameter  int RPldWidth  = 72,
  parameter  int MaxTxn     = 8,
  localparam int IdxW       = $clog2(NoMst),
  localparam int CntW       = $clog2(MaxTxn + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NoMst-1:0]           mst_ar_valid_i,
  output logic [NoMst-1:0]           mst_ar_ready_o,
  input  logic [NoMst*IdWidth-1:0]   mst_ar_id_i,
  input  logic [NoMst*2-1:0]         mst_ar_bar_i,
  input  logic [NoMst*ArPldWidth-1:0] mst_ar_pld_i,
  output logic                       slv_ar_valid_o,
  input  logic                       slv_ar_ready_i,
  output logic [IdWidth+IdxW-1:0]    slv_ar_id_o,
  output logic [1:0]                 slv_ar_bar_o,
  output logic [ArPldWidth-1:0]      slv_ar_pld_o,
  input  logic                       slv_r_valid_i,
  output logic                       slv_r_ready_o,
  input  logic [IdWidth+IdxW-1:0]    slv_r_id_i,
  input  logic                       slv_r_last_i,
  input  logic [RPldWidth-1:0]       slv_r_pld_i,
  output logic [NoMst-1:0]           mst_r_valid_o,
  input  logic [NoMst-1:0]           mst_r_ready_i,
  output logic [IdWidth-1:0]         mst_r_id_o,
  output logic                       mst_r_last_o,
  output logic [RPldWidth-1:0]       mst_r_pld_o
);

  logic [CntW-1:0]       cnt [NoMst];
  logic [IdxW-1:0]       rr_ptr, win_idx, next_ptr, r_idx;
  logic [NoMst-1:0]      elig, grant, inc_vec, dec_req, dec_vec;
  logic                  found, accept_ok, ar_fire, r_hit, r_done;
  logic [IdWidth-1:0]    sel_id;
  logic [1:0]            sel_bar;
  logic [ArPldWidth-1:0] sel_pld;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NoMst; i++) begin
      elig[i] = mst_ar_valid_i[i] && (cnt[i] < CntW'(MaxTxn));
`ifdef ACE_RD_ARB_BARRIER_EN
      if (mst_ar_bar_i[2*i] && (cnt[i] != '0)) elig[i] = 1'b0;
`endif
    end
  end

  // Scan from rr_ptr upward with wrap; first eligible requester wins.
  always_comb begin
    int k;
    k       = 0;
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int j = 0; j < NoMst; j++) begin
      k = (int'(rr_ptr) + j) % NoMst;
      if (!found && elig[IdxW'(k)]) begin
        found               = 1'b1;
        grant[IdxW'(k)]     = 1'b1;
        win_idx             = IdxW'(k);
      end
    end
  end

  assign accept_ok      = !slv_ar_valid_o || slv_ar_ready_i;
  assign mst_ar_ready_o = (rst_ni && accept_ok) ? grant : '0;
  assign ar_fire        = |mst_ar_ready_o;
  assign next_ptr       = (win_idx == IdxW'(NoMst - 1)) ? '0 : win_idx + IdxW'(1);

  always_comb begin
    sel_id  = '0;
    sel_bar = '0;
    sel_pld = '0;
    for (int i = 0; i < NoMst; i++) begin
      if (grant[i]) begin
        sel_id  = mst_ar_id_i[i*IdWidth +: IdWidth];
        sel_bar = mst_ar_bar_i[i*2 +: 2];
        sel_pld = mst_ar_pld_i[i*ArPldWidth +: ArPldWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slv_ar_valid_o <= 1'b0;
      slv_ar_id_o    <= '0;
      slv_ar_bar_o   <= '0;
      slv_ar_pld_o   <= '0;
      rr_ptr         <= '0;
    end else if (ar_fire) begin
      slv_ar_valid_o <= 1'b1;
      slv_ar_id_o    <= {win_idx, sel_id};
      slv_ar_bar_o   <= sel_bar;
      slv_ar_pld_o   <= sel_pld;
      rr_ptr         <= next_ptr;
    end else if (slv_ar_ready_i) begin
      slv_ar_valid_o <= 1'b0;
    end
  end

  // Index prefix beyond NoMst has no owner: sink the beat so the slave never stalls.
  assign r_idx = slv_r_id_i[IdWidth +: IdxW];

  always_comb begin
    mst_r_valid_o = '0;
    slv_r_ready_o = 1'b1;
    r_hit         = 1'b0;
    for (int i = 0; i < NoMst; i++) begin
      if (r_idx == IdxW'(i)) begin
        mst_r_valid_o[i] = slv_r_valid_i;
        slv_r_ready_o    = mst_r_ready_i[i];
        r_hit            = 1'b1;
      end
    end
  end

  assign mst_r_id_o   = slv_r_id_i[IdWidth-1:0];
  assign mst_r_last_o = slv_r_last_i;
  assign mst_r_pld_o  = slv_r_pld_i;
  assign r_done       = slv_r_valid_i && slv_r_ready_o && slv_r_last_i && r_hit;

  always_comb begin
    inc_vec = '0;
    dec_req = '0;
    dec_vec = '0;
    for (int i = 0; i < NoMst; i++) begin
      inc_vec[i] = ar_fire && grant[i];
      dec_req[i] = r_done && (r_idx == IdxW'(i));
      dec_vec[i] = dec_req[i] && (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NoMst; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NoMst; i++) begin
        if (inc_vec[i] && !dec_vec[i])      cnt[i] <= cnt[i] + CntW'(1);
        else if (dec_vec[i] && !inc_vec[i]) cnt[i] <= cnt[i] - CntW'(1);
      end
    end
  end

`ifndef SYNTHESIS
  // A last beat for a requester with nothing outstanding is a protocol error.
  assert property (@(posedge clk_i) disable iff (!rst_ni) (dec_req & ~dec_vec) == '0);
`endif

endmodule
